pd_word_uart_tx: RTL and testbench
==================================

# pd_word_uart_tx

Downstream consumer of the hash-separation stage. Accepts the 16-bit word stream that stage produces on `write_fifo`/`write_data` (16 hash words followed by sync word 16'h5400), buffers it in a small FIFO, and transmits each word as two 8N1 UART bytes, high byte first, on a single serial line to the host.

## Interface
- `DEPTH`, 32: FIFO depth in 16-bit words; power of two, ≥ 2.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); ≥ 2.
- `clk` in 1: single clock; everything updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `write_fifo` in 1: push strobe from the hash-separation stage; one word per cycle when high.
- `write_data` in 16: word pushed when `write_fifo` is high.
- `tx_serial` out 1: UART line; idle high.
- `busy` out 1: high while a frame (either byte) is on the line.
- `fifo_full` out 1: occupancy == `DEPTH`.
- `fifo_empty` out 1: occupancy == 0.
- `fifo_count` out $clog2(DEPTH+1): current occupancy.
- `overflow` out 1: sticky; set when a push is dropped; cleared only by `rst`.

## Operation
- Reset values: `tx_serial`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0, `overflow`=0, FSM in IDLE, pointers 0.
- FIFO: push when `write_fifo` and (not full or pop in same cycle); otherwise word dropped, `overflow` set. Push and pop in the same cycle: both happen, count unchanged. Pointers wrap modulo `DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if not empty, pop the head word into `word_q`, `byte_sel`=HI, go to START; else stay, `tx_serial`=1.
  - START: `tx_serial`=0 for `CLKS_PER_BIT` cycles, then DATA with `bit_idx`=0.
  - DATA: drive bit `bit_idx` of current byte (LSB first; HI = `word_q[15:8]`, LO = `word_q[7:0]`) for `CLKS_PER_BIT` cycles each; after bit 7 go to STOP.
  - STOP: `tx_serial`=1 for `CLKS_PER_BIT` cycles. Then: if `byte_sel`=HI, set LO, go to START. If LO and FIFO not empty, pop next word, `byte_sel`=HI, go to START (no idle gap). Else go to IDLE.
- `busy` high in START, DATA, STOP.
- Baud counter counts 0..`CLKS_PER_BIT`-1, reset on every state change.
- `rst` mid-frame: aborts frame; line returns high the next cycle; FIFO contents discarded.

## Timing
- All outputs registered.
- Push at edge N into empty FIFO: `fifo_empty` low after N; pop at edge N+1; `tx_serial` low (start bit) after edge N+2.
- One word = 20 × `CLKS_PER_BIT` cycles on the line; back-to-back words have no gap.
- Full 17-word burst (16 hash + sync) at `DEPTH`=32 never overflows.

## Structure
- Package `pd_tx_pkg`: FSM state enum (`tx_state_t`), `SYNC_WORD`=16'h5400, byte-select enum.
- Sub-module `pd_word_fifo` (parameter `DEPTH`, 16-bit data, push/pop/full/empty/count); top holds the FSM, baud counter, bit index, `word_q` and `overflow`.

## Test plan
- Reset: hold `rst` 2 cycles → `tx_serial`=1, `fifo_empty`=1, `fifo_count`=0, `overflow`=0, `busy`=0.
- Single word 16'h5400, `CLKS_PER_BIT`=4 → start bit, bits 0,0,1,0,1,0,1,0, stop, start, eight 0s, stop; 80 cycles total; `busy` falls after 80; `fifo_empty` high again.
- 17-word burst (16 hash words, then 16'h5400), `DEPTH`=32 → all 34 bytes decoded in order (HI then LO), 1360 cycles with no idle gap, `overflow`=0.
- Overflow, `DEPTH`=8: push w0..w9 on 10 consecutive cycles → w0 popped at cycle 1, w9 dropped, `overflow`=1; line carries w0..w8 only.
- Push and pop in the same cycle while full → count stays 8, pushed word later transmitted, `overflow` stays 0.
- `rst` during DATA of the second byte → `tx_serial`=1 the next cycle, `fifo_count`=0, `busy`=0; next push transmits normally.

Source files
------------

// File: rtl/pd_tx_pkg.sv
// Shared types and constants for the hash-word UART transmitter.
package pd_tx_pkg;

  localparam int unsigned WORD_W = 16;
  localparam logic [WORD_W-1:0] SYNC_WORD = 16'h5400;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_t;

  typedef enum logic {
    ByteHi,
    ByteLo
  } byte_sel_t;

endpackage

// File: rtl/pd_word_fifo.sv
// Word FIFO between the hash-separation stage and the UART framer; registered flags and count.
module pd_word_fifo
  import pd_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WORD_W-1:0]            push_data,
  input  logic                         pop,
  output logic [WORD_W-1:0]            pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q;
  logic              push_ok;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full_q || pop);
  assign dropped = push && !push_ok;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/pd_word_uart_tx.sv
// Buffers 16-bit hash/sync words and sends each as two 8N1 bytes, high byte first.
module pd_word_uart_tx
  import pd_tx_pkg::*;
#(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         write_fifo,
  input  logic [WORD_W-1:0]            write_data,
  output logic                         tx_serial,
  output logic                         busy,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t         state_q;
  byte_sel_t         byte_sel_q;
  logic [BW-1:0]     baud_q;
  logic [2:0]        bit_idx_q;
  logic [WORD_W-1:0] word_q;
  logic              tx_q, busy_q, overflow_q;

  logic              pop, dropped, baud_end, line_d;
  logic [WORD_W-1:0] head;
  logic [7:0]        cur_byte;

  pd_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (write_fifo),
    .push_data (write_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .dropped   (dropped)
  );

  assign baud_end = (baud_q == BAUD_LAST);
  assign cur_byte = (byte_sel_q == ByteHi) ? word_q[15:8] : word_q[7:0];

  // Pop on leaving IDLE, or at the end of a low-byte stop bit for gapless words.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:  pop = !fifo_empty;
      StStop:  pop = baud_end && (byte_sel_q == ByteLo) && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    case (state_q)
      StStart: line_d = 1'b0;
      StData:  line_d = cur_byte[bit_idx_q];
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_sel_q <= ByteHi;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (dropped) overflow_q <= 1'b1;
      // Line and busy follow the state one cycle later so both are clean flops.
      tx_q   <= line_d;
      busy_q <= (state_q != StIdle);
      case (state_q)
        StIdle: begin
          baud_q <= '0;
          if (pop) begin
            word_q     <= head;
            byte_sel_q <= ByteHi;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_end) begin
            baud_q <= '0;
            if (byte_sel_q == ByteHi) begin
              byte_sel_q <= ByteLo;
              state_q    <= StStart;
            end else if (pop) begin
              word_q     <= head;
              byte_sel_q <= ByteHi;
              state_q    <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_serial = tx_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pd_word_uart_tx.sv
// Directed bench: a DEPTH=32 and a DEPTH=8 instance, both at 4 clocks per bit.
module tb_pd_word_uart_tx;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wf32 = 1'b0, wf8 = 1'b0;
  logic [15:0] wd32 = '0, wd8 = '0;
  logic        tx32, busy32, full32, empty32, ovf32;
  logic        tx8, busy8, full8, empty8, ovf8;
  logic [5:0]  cnt32;
  logic [3:0]  cnt8;

  int errors = 0;
  int checks = 0;

  logic [15:0] pw [32];
  logic [15:0] lw [32];
  int          pt [32];
  logic [7:0]  cnt_at   [128];
  logic        full_at  [128];
  logic        empty_at [128];
  logic        ovf_at   [128];
  logic        tx_at    [128];
  logic        busy_at  [128];
  int          mism;

  always #5 clk = ~clk;

  pd_word_uart_tx #(.DEPTH(32), .CLKS_PER_BIT(CPB)) u_dut32 (
    .clk        (clk),
    .rst        (rst),
    .write_fifo (wf32),
    .write_data (wd32),
    .tx_serial  (tx32),
    .busy       (busy32),
    .fifo_full  (full32),
    .fifo_empty (empty32),
    .fifo_count (cnt32),
    .overflow   (ovf32)
  );

  pd_word_uart_tx #(.DEPTH(8), .CLKS_PER_BIT(CPB)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .write_fifo (wf8),
    .write_data (wd8),
    .tx_serial  (tx8),
    .busy       (busy8),
    .fifo_full  (full8),
    .fifo_empty (empty8),
    .fifo_count (cnt8),
    .overflow   (ovf8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic txm(input bit sel);
    return sel ? tx8 : tx32;
  endfunction

  function automatic logic busym(input bit sel);
    return sel ? busy8 : busy32;
  endfunction

  function automatic logic [7:0] cntm(input bit sel);
    return sel ? 8'(cnt8) : 8'(cnt32);
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [15:0] d);
    if (sel) begin
      wf8 = v;
      wd8 = d;
    end else begin
      wf32 = v;
      wd32 = d;
    end
  endtask

  // Expected line level k cycles into a word: start, 8 data bits LSB first, stop; per byte.
  function automatic logic line_bit(input logic [15:0] w, input int k);
    int         pos;
    logic [7:0] b;
    b   = (k < 40) ? w[15:8] : w[7:0];
    pos = (k % 40) / 4;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[3'(pos - 1)];
  endfunction

  // Push pw[i] at edge N+pt[i] (pt[0]=0) and compare the line cycle by cycle from edge N+2.
  task automatic stream(input bit sel, input int npush, input int nline, output int bad);
    int nx;
    int k;
    bad = 0;
    nx  = 1;
    drive(sel, 1'b1, pw[0]);
    for (int t = 0; t < nline * 80 + 3; t++) begin
      tick();
      if (t < 128) begin
        cnt_at[t]   = cntm(sel);
        full_at[t]  = sel ? full8 : full32;
        empty_at[t] = sel ? empty8 : empty32;
        ovf_at[t]   = sel ? ovf8 : ovf32;
        tx_at[t]    = txm(sel);
        busy_at[t]  = busym(sel);
      end
      if (nx < npush && pt[nx] == t + 1) begin
        drive(sel, 1'b1, pw[nx]);
        nx++;
      end else begin
        drive(sel, 1'b0, 16'h0);
      end
      if (t >= 2 && t < nline * 80 + 2) begin
        k = t - 2;
        if (txm(sel) !== line_bit(lw[k / 80], k % 80) || busym(sel) !== 1'b1) bad++;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 16'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset held two cycles.
    rst = 1'b1;
    tick();
    tick();
    check("rst_tx",     32'(tx32), 32'd1);
    check("rst_empty",  32'(empty32), 32'd1);
    check("rst_count",  32'(cnt32), 32'd0);
    check("rst_ovf",    32'(ovf32), 32'd0);
    check("rst_busy",   32'(busy32), 32'd0);
    check("rst_full8",  32'(full8), 32'd0);
    rst = 1'b0;

    // Single sync word.
    pw[0] = 16'h5400; lw[0] = 16'h5400; pt[0] = 0;
    stream(1'b0, 1, 1, mism);
    check("single_line",      32'(mism), 32'd0);
    check("single_cnt_t0",    32'(cnt_at[0]), 32'd1);
    check("single_empty_t0",  32'(empty_at[0]), 32'd0);
    check("single_empty_t1",  32'(empty_at[1]), 32'd1);
    check("single_tx_t1",     32'(tx_at[1]), 32'd1);
    check("single_busy_t1",   32'(busy_at[1]), 32'd0);
    check("single_tx_t2",     32'(tx_at[2]), 32'd0);
    check("single_busy_end",  32'(busy32), 32'd0);
    check("single_tx_end",    32'(tx32), 32'd1);
    check("single_empty_end", 32'(empty32), 32'd1);

    // 17-word burst into the DEPTH=32 instance.
    for (int i = 0; i < 16; i++) begin
      pw[i] = 16'hA5C3 ^ 16'(i * 32'h1357);
      pt[i] = i;
      lw[i] = pw[i];
    end
    pw[16] = 16'h5400; pt[16] = 16; lw[16] = 16'h5400;
    stream(1'b0, 17, 17, mism);
    check("burst_line",     32'(mism), 32'd0);
    check("burst_cnt_t16",  32'(cnt_at[16]), 32'd16);
    check("burst_ovf",      32'(ovf32), 32'd0);
    check("burst_busy_end", 32'(busy32), 32'd0);
    check("burst_empty",    32'(empty32), 32'd1);

    // Overflow: ten back-to-back pushes into DEPTH=8.
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      pw[i] = 16'h1E00 + 16'(i * 32'h0111);
      pt[i] = i;
      lw[i] = pw[i];
    end
    stream(1'b1, 10, 9, mism);
    check("ovf_line",      32'(mism), 32'd0);
    check("ovf_empty_t1",  32'(cnt_at[1]), 32'd1);
    check("ovf_cnt_t8",    32'(cnt_at[8]), 32'd8);
    check("ovf_full_t8",   32'(full_at[8]), 32'd1);
    check("ovf_flag_t8",   32'(ovf_at[8]), 32'd0);
    check("ovf_flag_t9",   32'(ovf_at[9]), 32'd1);
    check("ovf_cnt_t9",    32'(cnt_at[9]), 32'd8);
    check("ovf_sticky",    32'(ovf8), 32'd1);
    check("ovf_empty_end", 32'(empty8), 32'd1);

    // Push coinciding with the pop while full.
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      pw[i] = 16'hC001 + 16'(i * 32'h0203);
      pt[i] = i;
      lw[i] = pw[i];
    end
    pw[9] = 16'h7E81; pt[9] = 81; lw[9] = 16'h7E81;
    stream(1'b1, 10, 10, mism);
    check("pp_line",     32'(mism), 32'd0);
    check("pp_cnt_t80",  32'(cnt_at[80]), 32'd8);
    check("pp_full_t80", 32'(full_at[80]), 32'd1);
    check("pp_cnt_t81",  32'(cnt_at[81]), 32'd8);
    check("pp_full_t81", 32'(full_at[81]), 32'd1);
    check("pp_ovf_t81",  32'(ovf_at[81]), 32'd0);
    check("pp_ovf_end",  32'(ovf8), 32'd0);

    // Reset during the data bits of the low byte.
    pulse_reset();
    drive(1'b0, 1'b1, 16'hBE27);
    tick();
    drive(1'b0, 1'b1, 16'h1234);
    tick();
    drive(1'b0, 1'b0, 16'h0);
    repeat (58) tick();
    check("mid_busy",  32'(busy32), 32'd1);
    check("mid_tx",    32'(tx32), 32'd0);
    check("mid_count", 32'(cnt32), 32'd1);
    rst = 1'b1;
    tick();
    check("abort_tx",    32'(tx32), 32'd1);
    check("abort_count", 32'(cnt32), 32'd0);
    check("abort_busy",  32'(busy32), 32'd0);
    check("abort_empty", 32'(empty32), 32'd1);
    rst = 1'b0;
    tick();
    pw[0] = 16'h0F31; lw[0] = 16'h0F31; pt[0] = 0;
    stream(1'b0, 1, 1, mism);
    check("after_rst_line", 32'(mism), 32'd0);
    check("after_rst_busy", 32'(busy32), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
